dcmac_tx_arbiter: RTL and testbench

Packet-granular round-robin arbiter that shares one DCMAC TX segmented port between two requesters. Each requester presents full-width segmented beats, and every packet starts on segment 0. The block grants one requester at a time, holds the grant until that packet's end-of-packet beat, and forwards beats through a single output register stage. It sits upstream of the DCMAC TX client interface and is the transmit-side counterpart of the RX segment deskew logic.

---
 rtl/dcmac_tx_arbiter.sv | 174 +++++++++++++++++
 tb/tb_dcmac_tx_arbiter.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/dcmac_tx_arbiter.sv
// Packet-granular round-robin arbiter sharing one DCMAC TX segmented port
// between two requesters, with a single registered output stage.
module dcmac_tx_arbiter #(
  parameter int unsigned SEG_COUNT = 4
) (
  input  logic         clk,
  input  logic         resetn,
  input  logic         enable,
  input  logic [511:0] s0_tdata,
  input  logic [63:0]  s0_tkeep,
  input  logic [7:0]   s0_tuser,
  input  logic [3:0]   s0_tlast,
  input  logic         s0_tvalid,
  output logic         s0_tready,
  input  logic [511:0] s1_tdata,
  input  logic [63:0]  s1_tkeep,
  input  logic [7:0]   s1_tuser,
  input  logic [3:0]   s1_tlast,
  input  logic         s1_tvalid,
  output logic         s1_tready,
  output logic [511:0] m_tdata,
  output logic [63:0]  m_tkeep,
  output logic [7:0]   m_tuser,
  output logic [3:0]   m_tlast,
  output logic         m_tvalid,
  input  logic         m_tready,
  output logic         busy,
  output logic         owner,
  output logic [31:0]  pkt_count0,
  output logic [31:0]  pkt_count1
);

  localparam int unsigned SEG_N   = 4;
  localparam int unsigned DATA_W  = 512;
  localparam int unsigned KEEP_W  = 64;
  localparam int unsigned USER_W  = 8;
  localparam int unsigned CNT_W   = 32;
  localparam int unsigned SEG_DW  = DATA_W / SEG_N;
  localparam int unsigned SEG_KW  = KEEP_W / SEG_N;
  localparam int unsigned SEG_UW  = USER_W / SEG_N;
  localparam logic [SEG_N-1:0] SEG_MASK = (SEG_COUNT == 2) ? 4'b0011 : 4'b1111;

  typedef struct packed {
    logic [DATA_W-1:0] tdata;
    logic [KEEP_W-1:0] tkeep;
    logic [USER_W-1:0] tuser;
    logic [SEG_N-1:0]  tlast;
  } beat_t;

  typedef enum logic {ST_IDLE, ST_BUSY} state_t;

  state_t             state_q, state_d;
  logic               last_q, last_d;
  logic               owner_q, owner_d;
  logic               busy_q, busy_d;
  logic [CNT_W-1:0]   cnt0_q, cnt0_d;
  logic [CNT_W-1:0]   cnt1_q, cnt1_d;
  beat_t              mbeat_q, mbeat_d;
  logic               mvalid_q, mvalid_d;

  logic  can_load;
  logic  sel;
  logic  sel_vld;
  logic  in_valid;
  logic  accept;
  logic  eop;
  beat_t in_beat;
  beat_t masked;

  // Grant selection and ready generation; ready never looks at the owner's tvalid
  always_comb begin
    can_load = ~mvalid_q | m_tready;
    sel      = 1'b0;
    sel_vld  = 1'b0;
    if (state_q == ST_BUSY) begin
      sel     = owner_q;
      sel_vld = 1'b1;
    end else if (enable) begin
      sel     = (s0_tvalid && s1_tvalid) ? ~last_q : s1_tvalid;
      sel_vld = s0_tvalid | s1_tvalid;
    end
    s0_tready = sel_vld & ~sel & can_load;
    s1_tready = sel_vld &  sel & can_load;
    in_valid  = sel ? s1_tvalid : s0_tvalid;
    in_beat   = sel ? beat_t'{s1_tdata, s1_tkeep, s1_tuser, s1_tlast}
                    : beat_t'{s0_tdata, s0_tkeep, s0_tuser, s0_tlast};
    accept    = sel_vld & can_load & in_valid;
    eop       = |(in_beat.tlast & SEG_MASK);
  end

  // Zero every field of segments outside the configured segment count
  always_comb begin
    masked = in_beat;
    for (int k = 0; k < SEG_N; k++) begin
      if (!SEG_MASK[k]) begin
        masked.tdata[SEG_DW*k +: SEG_DW] = '0;
        masked.tkeep[SEG_KW*k +: SEG_KW] = '0;
        masked.tuser[SEG_UW*k +: SEG_UW] = '0;
        masked.tlast[k]                  = 1'b0;
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    last_d   = last_q;
    owner_d  = owner_q;
    cnt0_d   = cnt0_q;
    cnt1_d   = cnt1_q;
    mbeat_d  = mbeat_q;
    mvalid_d = mvalid_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          owner_d = sel;
          if (eop) last_d  = sel;
          else     state_d = ST_BUSY;
        end
      end
      ST_BUSY: begin
        if (accept && eop) begin
          state_d = ST_IDLE;
          last_d  = owner_q;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (accept && eop) begin
      if (sel) cnt1_d = cnt1_q + CNT_W'(1);
      else     cnt0_d = cnt0_q + CNT_W'(1);
    end
    busy_d = (state_d == ST_BUSY);
    if (accept) begin
      mbeat_d  = masked;
      mvalid_d = 1'b1;
    end else if (m_tready) begin
      mvalid_d = 1'b0;
    end
  end

  // Reset favours requester 0 on the first tie by marking requester 1 as last served
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q  <= ST_IDLE;
      last_q   <= 1'b1;
      owner_q  <= 1'b0;
      busy_q   <= 1'b0;
      cnt0_q   <= '0;
      cnt1_q   <= '0;
      mbeat_q  <= '0;
      mvalid_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      last_q   <= last_d;
      owner_q  <= owner_d;
      busy_q   <= busy_d;
      cnt0_q   <= cnt0_d;
      cnt1_q   <= cnt1_d;
      mbeat_q  <= mbeat_d;
      mvalid_q <= mvalid_d;
    end
  end

  assign m_tdata    = mbeat_q.tdata;
  assign m_tkeep    = mbeat_q.tkeep;
  assign m_tuser    = mbeat_q.tuser;
  assign m_tlast    = mbeat_q.tlast;
  assign m_tvalid   = mvalid_q;
  assign busy       = busy_q;
  assign owner      = owner_q;
  assign pkt_count0 = cnt0_q;
  assign pkt_count1 = cnt1_q;

endmodule

// File: tb/tb_dcmac_tx_arbiter.sv
// Directed vector bench for dcmac_tx_arbiter (4-segment and 2-segment builds).
module tb_dcmac_tx_arbiter;

  logic         clk = 1'b0;
  logic         resetn;
  logic         enable;
  logic [511:0] s0_tdata, s1_tdata;
  logic [63:0]  s0_tkeep, s1_tkeep;
  logic [7:0]   s0_tuser, s1_tuser;
  logic [3:0]   s0_tlast, s1_tlast;
  logic         s0_tvalid, s1_tvalid;
  logic         m_tready;

  logic         s0_tready, s1_tready;
  logic [511:0] m_tdata;
  logic [63:0]  m_tkeep;
  logic [7:0]   m_tuser;
  logic [3:0]   m_tlast;
  logic         m_tvalid, busy, owner;
  logic [31:0]  pkt_count0, pkt_count1;

  logic         d2_s0_tready, d2_s1_tready;
  logic [511:0] d2_m_tdata;
  logic [63:0]  d2_m_tkeep;
  logic [7:0]   d2_m_tuser;
  logic [3:0]   d2_m_tlast;
  logic         d2_m_tvalid, d2_busy, d2_owner;
  logic [31:0]  d2_pkt_count0, d2_pkt_count1;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  dcmac_tx_arbiter #(.SEG_COUNT(4)) u_dut4 (
    .clk(clk), .resetn(resetn), .enable(enable),
    .s0_tdata(s0_tdata), .s0_tkeep(s0_tkeep), .s0_tuser(s0_tuser), .s0_tlast(s0_tlast),
    .s0_tvalid(s0_tvalid), .s0_tready(s0_tready),
    .s1_tdata(s1_tdata), .s1_tkeep(s1_tkeep), .s1_tuser(s1_tuser), .s1_tlast(s1_tlast),
    .s1_tvalid(s1_tvalid), .s1_tready(s1_tready),
    .m_tdata(m_tdata), .m_tkeep(m_tkeep), .m_tuser(m_tuser), .m_tlast(m_tlast),
    .m_tvalid(m_tvalid), .m_tready(m_tready),
    .busy(busy), .owner(owner), .pkt_count0(pkt_count0), .pkt_count1(pkt_count1)
  );

  dcmac_tx_arbiter #(.SEG_COUNT(2)) u_dut2 (
    .clk(clk), .resetn(resetn), .enable(enable),
    .s0_tdata(s0_tdata), .s0_tkeep(s0_tkeep), .s0_tuser(s0_tuser), .s0_tlast(s0_tlast),
    .s0_tvalid(s0_tvalid), .s0_tready(d2_s0_tready),
    .s1_tdata(s1_tdata), .s1_tkeep(s1_tkeep), .s1_tuser(s1_tuser), .s1_tlast(s1_tlast),
    .s1_tvalid(s1_tvalid), .s1_tready(d2_s1_tready),
    .m_tdata(d2_m_tdata), .m_tkeep(d2_m_tkeep), .m_tuser(d2_m_tuser), .m_tlast(d2_m_tlast),
    .m_tvalid(d2_m_tvalid), .m_tready(m_tready),
    .busy(d2_busy), .owner(d2_owner), .pkt_count0(d2_pkt_count0), .pkt_count1(d2_pkt_count1)
  );

  typedef struct {
    logic        rst;
    logic        v0;
    logic [3:0]  l0;
    logic [7:0]  t0;
    logic        v1;
    logic [3:0]  l1;
    logic [7:0]  t1;
    logic        en;
    logic        mr;
    logic        er0;
    logic        er1;
    logic        emv;
    logic [7:0]  etag;
    logic [3:0]  elast;
    logic        ebusy;
    logic        eown;
    logic [31:0] ec0;
    logic [31:0] ec1;
  } vec_t;

  vec_t vq[$];

  task automatic chk(input string nm, input logic [511:0] act, input logic [511:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic add(input logic rst, input logic v0, input logic [3:0] l0, input logic [7:0] t0,
                     input logic v1, input logic [3:0] l1, input logic [7:0] t1,
                     input logic en, input logic mr, input logic er0, input logic er1,
                     input logic emv, input logic [7:0] etag, input logic [3:0] elast,
                     input logic ebusy, input logic eown, input logic [31:0] ec0,
                     input logic [31:0] ec1);
    vec_t v;
    v.rst = rst; v.v0 = v0; v.l0 = l0; v.t0 = t0; v.v1 = v1; v.l1 = l1; v.t1 = t1;
    v.en = en; v.mr = mr; v.er0 = er0; v.er1 = er1; v.emv = emv; v.etag = etag;
    v.elast = elast; v.ebusy = ebusy; v.eown = eown; v.ec0 = ec0; v.ec1 = ec1;
    vq.push_back(v);
  endtask

  task automatic drive(input logic v0, input logic [3:0] l0, input logic [7:0] t0,
                       input logic v1, input logic [3:0] l1, input logic [7:0] t1,
                       input logic en, input logic mr);
    s0_tvalid = v0; s0_tlast = l0; s0_tdata = {64{t0}};
    s1_tvalid = v1; s1_tlast = l1; s1_tdata = {64{t1}};
    enable = en; m_tready = mr;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    resetn = 1'b0;
    s0_tkeep = '1; s1_tkeep = '1; s0_tuser = 8'hA5; s1_tuser = 8'hA5;
    drive(0, 4'h0, 8'h00, 0, 4'h0, 8'h00, 1, 1);
    tick(); tick();
    chk("rst_mvalid", 512'(m_tvalid), 512'(0));
    chk("rst_busy", 512'(busy), 512'(0));
    chk("rst_owner", 512'(owner), 512'(0));
    chk("rst_mdata", m_tdata, 512'(0));
    chk("rst_cnt0", 512'(pkt_count0), 512'(0));
    resetn = 1'b1;

    // s0 3-beat packet, eop on segment 2
    add(0, 1,4'h0,8'h01, 0,4'h0,8'h00, 1,1, 1,0, 1,8'h01,4'h0, 1,0, 0,0);
    add(0, 1,4'h0,8'h02, 0,4'h0,8'h00, 1,1, 1,0, 1,8'h02,4'h0, 1,0, 0,0);
    add(0, 1,4'h4,8'h03, 0,4'h0,8'h00, 1,1, 1,0, 1,8'h03,4'h4, 0,0, 1,0);
    add(0, 0,4'h0,8'h00, 0,4'h0,8'h00, 1,1, 0,0, 0,8'h00,4'h0, 0,0, 1,0);
    // both valid, 2-beat packets alternate starting with s0
    add(1, 1,4'h0,8'hA1, 1,4'h0,8'hB1, 1,1, 1,0, 1,8'hA1,4'h0, 1,0, 0,0);
    add(0, 1,4'h1,8'hA2, 1,4'h0,8'hB1, 1,1, 1,0, 1,8'hA2,4'h1, 0,0, 1,0);
    add(0, 1,4'h0,8'hA3, 1,4'h0,8'hB1, 1,1, 0,1, 1,8'hB1,4'h0, 1,1, 1,0);
    add(0, 1,4'h0,8'hA3, 1,4'h1,8'hB2, 1,1, 0,1, 1,8'hB2,4'h1, 0,1, 1,1);
    add(0, 1,4'h0,8'hA3, 1,4'h0,8'hB3, 1,1, 1,0, 1,8'hA3,4'h0, 1,0, 1,1);
    add(0, 1,4'h1,8'hA4, 1,4'h0,8'hB3, 1,1, 1,0, 1,8'hA4,4'h1, 0,0, 2,1);
    add(0, 1,4'h0,8'hA5, 1,4'h0,8'hB3, 1,1, 0,1, 1,8'hB3,4'h0, 1,1, 2,1);
    add(0, 1,4'h0,8'hA5, 1,4'h1,8'hB4, 1,1, 0,1, 1,8'hB4,4'h1, 0,1, 2,2);
    // s0 mid-packet with s1 waiting, m_tready 1,0,0,1
    add(0, 1,4'h0,8'hC1, 0,4'h0,8'h00, 1,1, 1,0, 1,8'hC1,4'h0, 1,0, 2,2);
    add(0, 1,4'h0,8'hC2, 1,4'h0,8'hD1, 1,1, 1,0, 1,8'hC2,4'h0, 1,0, 2,2);
    add(0, 1,4'h1,8'hC3, 1,4'h0,8'hD1, 1,0, 0,0, 1,8'hC2,4'h0, 1,0, 2,2);
    add(0, 1,4'h1,8'hC3, 1,4'h0,8'hD1, 1,0, 0,0, 1,8'hC2,4'h0, 1,0, 2,2);
    add(0, 1,4'h1,8'hC3, 1,4'h0,8'hD1, 1,1, 1,0, 1,8'hC3,4'h1, 0,0, 3,2);
    add(0, 0,4'h0,8'h00, 1,4'h1,8'hD1, 1,1, 0,1, 1,8'hD1,4'h1, 0,1, 3,3);
    add(0, 0,4'h0,8'h00, 0,4'h0,8'h00, 1,1, 0,0, 0,8'h00,4'h0, 0,1, 3,3);
    // enable dropped during beat 2 of 4
    add(0, 1,4'h0,8'hE1, 0,4'h0,8'h00, 1,1, 1,0, 1,8'hE1,4'h0, 1,0, 3,3);
    add(0, 1,4'h0,8'hE2, 1,4'h1,8'hF1, 0,1, 1,0, 1,8'hE2,4'h0, 1,0, 3,3);
    add(0, 1,4'h0,8'hE3, 1,4'h1,8'hF1, 0,1, 1,0, 1,8'hE3,4'h0, 1,0, 3,3);
    add(0, 1,4'h8,8'hE4, 1,4'h1,8'hF1, 0,1, 1,0, 1,8'hE4,4'h8, 0,0, 4,3);
    add(0, 0,4'h0,8'h00, 1,4'h1,8'hF1, 0,1, 0,0, 0,8'h00,4'h0, 0,0, 4,3);
    add(0, 0,4'h0,8'h00, 1,4'h1,8'hF1, 0,1, 0,0, 0,8'h00,4'h0, 0,0, 4,3);
    add(0, 0,4'h0,8'h00, 1,4'h1,8'hF1, 1,1, 0,1, 1,8'hF1,4'h1, 0,1, 4,4);

    foreach (vq[i]) begin
      if (vq[i].rst) begin
        resetn = 1'b0;
        #2;
        chk($sformatf("v%0d_rst_mvalid", i), 512'(m_tvalid), 512'(0));
        resetn = 1'b1;
      end
      drive(vq[i].v0, vq[i].l0, vq[i].t0, vq[i].v1, vq[i].l1, vq[i].t1, vq[i].en, vq[i].mr);
      #1;
      chk($sformatf("v%0d_s0_tready", i), 512'(s0_tready), 512'(vq[i].er0));
      chk($sformatf("v%0d_s1_tready", i), 512'(s1_tready), 512'(vq[i].er1));
      tick();
      chk($sformatf("v%0d_m_tvalid", i), 512'(m_tvalid), 512'(vq[i].emv));
      chk($sformatf("v%0d_busy", i), 512'(busy), 512'(vq[i].ebusy));
      chk($sformatf("v%0d_owner", i), 512'(owner), 512'(vq[i].eown));
      chk($sformatf("v%0d_cnt0", i), 512'(pkt_count0), 512'(vq[i].ec0));
      chk($sformatf("v%0d_cnt1", i), 512'(pkt_count1), 512'(vq[i].ec1));
      if (vq[i].emv) begin
        chk($sformatf("v%0d_m_tdata", i), m_tdata, {64{vq[i].etag}});
        chk($sformatf("v%0d_m_tlast", i), 512'(m_tlast), 512'(vq[i].elast));
        chk($sformatf("v%0d_m_tuser", i), 512'(m_tuser), 512'(8'hA5));
      end
    end

    // asynchronous reset mid-packet, then s1 alone
    drive(1, 4'h0, 8'h71, 0, 4'h0, 8'h00, 1, 1);
    tick();
    chk("ar_busy_before", 512'(busy), 512'(1));
    resetn = 1'b0;
    #1;
    chk("ar_mvalid", 512'(m_tvalid), 512'(0));
    chk("ar_busy", 512'(busy), 512'(0));
    chk("ar_cnt0", 512'(pkt_count0), 512'(0));
    chk("ar_cnt1", 512'(pkt_count1), 512'(0));
    chk("ar_mdata", m_tdata, 512'(0));
    drive(0, 4'h0, 8'h00, 1, 4'h1, 8'h72, 1, 1);
    resetn = 1'b1;
    #1;
    chk("ar_s0_tready", 512'(s0_tready), 512'(0));
    chk("ar_s1_tready", 512'(s1_tready), 512'(1));
    tick();
    chk("ar_post_mvalid", 512'(m_tvalid), 512'(1));
    chk("ar_post_mdata", m_tdata, {64{8'h72}});
    chk("ar_post_owner", 512'(owner), 512'(1));
    chk("ar_post_busy", 512'(busy), 512'(0));
    chk("ar_post_cnt1", 512'(pkt_count1), 512'(1));
    chk("ar_post_cnt0", 512'(pkt_count0), 512'(0));

    // two-segment build: upper-segment tlast is not eop and is masked off
    drive(0, 4'h0, 8'h00, 0, 4'h0, 8'h00, 1, 1);
    tick();
    resetn = 1'b0;
    #2;
    resetn = 1'b1;
    drive(0, 4'h0, 8'h00, 1, 4'h4, 8'hFF, 1, 1);
    #1;
    chk("s2_s1_tready", 512'(d2_s1_tready), 512'(1));
    tick();
    chk("s2_busy", 512'(d2_busy), 512'(1));
    chk("s2_owner", 512'(d2_owner), 512'(1));
    chk("s2_mvalid", 512'(d2_m_tvalid), 512'(1));
    chk("s2_mkeep", 512'(d2_m_tkeep), 512'(64'h0000_0000_FFFF_FFFF));
    chk("s2_mlast", 512'(d2_m_tlast), 512'(0));
    chk("s2_mdata", d2_m_tdata, {256'h0, {32{8'hFF}}});
    chk("s2_muser", 512'(d2_m_tuser), 512'(8'h05));
    chk("s2_cnt1_mid", 512'(d2_pkt_count1), 512'(0));
    drive(0, 4'h0, 8'h00, 1, 4'h1, 8'h3C, 1, 1);
    #1;
    chk("s2_s1_tready_eop", 512'(d2_s1_tready), 512'(1));
    tick();
    chk("s2_busy_end", 512'(d2_busy), 512'(0));
    chk("s2_cnt1_end", 512'(d2_pkt_count1), 512'(1));
    chk("s2_mlast_end", 512'(d2_m_tlast), 512'(1));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
